// File: rtl/fork_cond2_ctrl_2ph.sv
// fork_cond2_ctrl_2ph
// Clocked sequencer driving a 2-channel conditional fork over a 2-phase
// single-rail channel. It latches the routing condition, holds it through
// a setup window, toggles r once, and waits for the matching ack phase.
// It also counts completed tokens per branch and flags ack timeouts.
module fork_cond2_ctrl_2ph #(
  parameter int CNT_W       = 16,
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT     = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mask,
  output logic             r,
  input  logic             a,
  output logic             cond1,
  output logic             cond2,
  output logic             busy,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic             err_timeout,
  input  logic             err_clr
);

  localparam int SW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] aSync_q;
  logic                   aS;

  logic [SW-1:0]    setupCnt_q, setupCnt_d;
  logic [TW-1:0]    waitCnt_q, waitCnt_d;
  logic             r_q, r_d;
  logic             cond1_q, cond1_d;
  logic             cond2_q, cond2_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [CNT_W-1:0] cnt2_q, cnt2_d;
  logic             err_q, err_d;

  logic acceptToken;
  logic setupLast;
  logic ackDone;
  logic timeoutHit;

  assign aS = aSync_q[SYNC_STAGES-1];

  assign acceptToken = (state_q == IDLE) && cmd_valid && (cmd_mask != 2'b00);
  assign setupLast   = (state_q == SETUP) && (setupCnt_q == SW'(SETUP_CYC - 1));
  assign ackDone     = (state_q == WAIT) && (aS == r_q);
  assign timeoutHit  = (state_q == WAIT) && !ackDone && (waitCnt_q == TW'(TIMEOUT - 1));

  // Bring the asynchronous ack into the clock domain through a flop chain
  always_ff @(posedge clk) begin
    if (rst) begin
      aSync_q <= '0;
    end else begin
      aSync_q <= {aSync_q[SYNC_STAGES-2:0], a};
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: zero masks are dropped in IDLE, a token cannot be aborted once r toggles
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acceptToken) state_d = SETUP;
      SETUP:   if (setupLast)   state_d = WAIT;
      WAIT:    if (ackDone)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: handshake and status derive only from the state register
  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
  end

  // Datapath next-state: condition latch, r toggle, counters and sticky timeout flag
  always_comb begin
    setupCnt_d = setupCnt_q;
    waitCnt_d  = waitCnt_q;
    r_d        = r_q;
    cond1_d    = cond1_q;
    cond2_d    = cond2_q;
    cnt1_d     = cnt1_q;
    cnt2_d     = cnt2_q;
    err_d      = err_q;

    if (acceptToken) begin
      cond1_d    = cmd_mask[0];
      cond2_d    = cmd_mask[1];
      setupCnt_d = '0;
    end

    if (state_q == SETUP) begin
      if (setupLast) begin
        r_d       = ~r_q;
        waitCnt_d = '0;
      end else begin
        setupCnt_d = setupCnt_q + 1'b1;
      end
    end

    if ((state_q == WAIT) && !ackDone && (waitCnt_q != TW'(TIMEOUT))) begin
      waitCnt_d = waitCnt_q + 1'b1;
    end

    if (ackDone) begin
      if (cond1_q && (cnt1_q != CNT_MAX)) cnt1_d = cnt1_q + 1'b1;
      if (cond2_q && (cnt2_q != CNT_MAX)) cnt2_d = cnt2_q + 1'b1;
    end

    if (timeoutHit) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // Datapath registers; r and cond feed the async fork straight from these flops
  always_ff @(posedge clk) begin
    if (rst) begin
      setupCnt_q <= '0;
      waitCnt_q  <= '0;
      r_q        <= 1'b0;
      cond1_q    <= 1'b0;
      cond2_q    <= 1'b0;
      cnt1_q     <= '0;
      cnt2_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      setupCnt_q <= setupCnt_d;
      waitCnt_q  <= waitCnt_d;
      r_q        <= r_d;
      cond1_q    <= cond1_d;
      cond2_q    <= cond2_d;
      cnt1_q     <= cnt1_d;
      cnt2_q     <= cnt2_d;
      err_q      <= err_d;
    end
  end

  assign r           = r_q;
  assign cond1       = cond1_q;
  assign cond2       = cond2_q;
  assign cnt1        = cnt1_q;
  assign cnt2        = cnt2_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_fork_cond2_ctrl_2ph.sv
// Testbench for fork_cond2_ctrl_2ph: a behavioural fork answers r with a
// programmable lag, stimulus pushes expected completions into a queue and
// a monitor pops and compares them when each transaction ends.
module tb_fork_cond2_ctrl_2ph;

  localparam int CNT_W       = 2;
  localparam int SETUP_CYC   = 2;
  localparam int TIMEOUT     = 1024;
  localparam int SYNC_STAGES = 2;
  localparam int MAXC        = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mask;
  logic             r;
  logic             a;
  logic             cond1;
  logic             cond2;
  logic             busy;
  logic [CNT_W-1:0] cnt1;
  logic [CNT_W-1:0] cnt2;
  logic             err_timeout;
  logic             err_clr;

  fork_cond2_ctrl_2ph #(
    .CNT_W(CNT_W),
    .SETUP_CYC(SETUP_CYC),
    .TIMEOUT(TIMEOUT),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_mask(cmd_mask),
    .r(r),
    .a(a),
    .cond1(cond1),
    .cond2(cond2),
    .busy(busy),
    .cnt1(cnt1),
    .cnt2(cnt2),
    .err_timeout(err_timeout),
    .err_clr(err_clr)
  );

  typedef struct {
    logic c1;
    logic c2;
    logic rr;
    int   n1;
    int   n2;
    int   busyCyc;
  } exp_t;

  exp_t expQ[$];

  int  errors = 0;
  int  checks = 0;
  int  mR, m1, m2;
  int  ackDelay = 0;
  bit  ackEn = 1'b1;
  int  lag = 0;
  bit  prevBusy = 1'b0;
  int  busyCnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Behavioural fork: copies r onto a after ackDelay negedges, drops to 0 when reset
  initial begin
    a = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        a   = 1'b0;
        lag = 0;
      end else if (ackEn && (a !== r)) begin
        if (lag >= ackDelay) begin
          a   = r;
          lag = 0;
        end else begin
          lag++;
        end
      end else begin
        lag = 0;
      end
    end
  end

  // Monitor: checks condition hold during each transaction and pops on completion
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prevBusy = 1'b0;
        busyCnt  = 0;
      end else begin
        chk("ready_vs_busy", {31'b0, cmd_ready}, {31'b0, !busy});
        if (busy && !prevBusy) begin
          busyCnt = 1;
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_start: busy rose with no command outstanding");
          end else begin
            chk("start_cond1", {31'b0, cond1}, {31'b0, expQ[0].c1});
            chk("start_cond2", {31'b0, cond2}, {31'b0, expQ[0].c2});
            chk("start_r_old", {31'b0, r}, {31'b0, !expQ[0].rr});
          end
        end else if (busy) begin
          busyCnt++;
          if (expQ.size() > 0) begin
            chk("hold_cond", {30'b0, cond2, cond1}, {30'b0, expQ[0].c2, expQ[0].c1});
          end
        end
        if (!busy && prevBusy) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done: transaction ended with empty queue");
          end else begin
            e = expQ.pop_front();
            chk("done_r", {31'b0, r}, {31'b0, e.rr});
            chk("done_cond", {30'b0, cond2, cond1}, {30'b0, e.c2, e.c1});
            chk("done_cnt1", 32'(cnt1), 32'(e.n1));
            chk("done_cnt2", 32'(cnt2), 32'(e.n2));
            if (e.busyCyc >= 0) chk("busy_cycles", 32'(busyCnt), 32'(e.busyCyc));
          end
        end
        prevBusy = busy;
      end
    end
  end

  // Hard stop in case something hangs outside the bounded waits
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic resetDut();
    @(negedge clk);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    expQ.delete();
    mR = 0;
    m1 = 0;
    m2 = 0;
    @(negedge clk);
    chk("rst_r", {31'b0, r}, 32'd0);
    chk("rst_cond", {30'b0, cond2, cond1}, 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    chk("rst_cnt2", 32'(cnt2), 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_err", {31'b0, err_timeout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] mask, input int d);
    int   guard;
    exp_t e;
    guard = 0;
    while (!cmd_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_wait: cmd_ready still 0 after %0d cycles", guard);
      return;
    end
    ackDelay  = d;
    cmd_valid = 1'b1;
    cmd_mask  = mask;
    if (mask != 2'b00) begin
      mR = mR ^ 1;
      if (mask[0] && m1 < MAXC) m1++;
      if (mask[1] && m2 < MAXC) m2++;
      e.c1      = mask[0];
      e.c2      = mask[1];
      e.rr      = mR[0];
      e.n1      = m1;
      e.n2      = m2;
      e.busyCyc = ackEn ? (SETUP_CYC + d + SYNC_STAGES + 1) : -1;
      expQ.push_back(e);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    if (mask == 2'b00) begin
      chk("drop_ready", {31'b0, cmd_ready}, 32'd1);
      chk("drop_busy", {31'b0, busy}, 32'd0);
      chk("drop_r", {31'b0, r}, 32'(mR));
      chk("drop_cnt1", 32'(cnt1), 32'(m1));
      chk("drop_cnt2", 32'(cnt2), 32'(m2));
    end
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while (busy && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_wait: busy still 1 after %0d cycles", guard);
    end
    @(negedge clk);
  endtask

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] expv);
    chk(nm, act, expv);
  endtask

  // Main sequence: directed scenarios first, then randomized traffic
  initial begin
    int guard;
    logic rPrev;
    logic [1:0] m;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_mask  = 2'b00;
    err_clr   = 1'b0;
    mR = 0;
    m1 = 0;
    m2 = 0;
    repeat (2) @(negedge clk);
    resetDut();

    // Single mask=01 token with a 3-cycle ack loopback
    applyStimulus(2'b01, 3);
    waitIdle();
    checkOutput("t1_cnt1", 32'(cnt1), 32'd1);
    checkOutput("t1_cnt2", 32'(cnt2), 32'd0);
    checkOutput("t1_r", {31'b0, r}, 32'd1);

    // Back-to-back 11, 10, 11 with prompt ack
    resetDut();
    applyStimulus(2'b11, 0);
    applyStimulus(2'b10, 0);
    applyStimulus(2'b11, 0);
    waitIdle();
    checkOutput("t2_r", {31'b0, r}, 32'd1);
    checkOutput("t2_cnt1", 32'(cnt1), 32'd2);
    checkOutput("t2_cnt2", 32'(cnt2), 32'd3);

    // Zero masks are dropped and can be accepted back to back
    applyStimulus(2'b00, 0);
    applyStimulus(2'b00, 0);

    // Counter saturation at 2^CNT_W-1
    resetDut();
    repeat (5) applyStimulus(2'b01, $urandom_range(0, 2));
    waitIdle();
    checkOutput("sat_cnt1", 32'(cnt1), 32'(MAXC));
    checkOutput("sat_cnt2", 32'(cnt2), 32'd0);

    // Ack timeout, set beats a simultaneous clear, late ack still completes
    resetDut();
    ackEn   = 1'b0;
    err_clr = 1'b1;
    rPrev   = r;
    applyStimulus(2'b01, 0);
    guard = 0;
    while (r == rPrev && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("to_r_toggled", {31'b0, r}, {31'b0, !rPrev});
    repeat (TIMEOUT - 1) @(negedge clk);
    checkOutput("to_err_before", {31'b0, err_timeout}, 32'd0);
    @(negedge clk);
    checkOutput("to_err_set", {31'b0, err_timeout}, 32'd1);
    err_clr = 1'b0;
    repeat (70) @(negedge clk);
    checkOutput("to_err_held", {31'b0, err_timeout}, 32'd1);
    checkOutput("to_busy", {31'b0, busy}, 32'd1);
    ackEn = 1'b1;
    waitIdle();
    checkOutput("to_err_after_ack", {31'b0, err_timeout}, 32'd1);
    checkOutput("to_cnt1", 32'(cnt1), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("to_err_cleared", {31'b0, err_timeout}, 32'd0);

    // Reset during WAIT with r=1 abandons the token, then normal operation resumes
    resetDut();
    applyStimulus(2'b01, 0);
    waitIdle();
    ackEn = 1'b0;
    applyStimulus(2'b01, 0);
    guard = 0;
    while (r == 1'b0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("rw_r_high", {31'b0, r}, 32'd1);
    checkOutput("rw_busy", {31'b0, busy}, 32'd1);
    resetDut();
    ackEn = 1'b1;
    applyStimulus(2'b10, 1);
    waitIdle();
    checkOutput("rw_cnt1", 32'(cnt1), 32'd0);
    checkOutput("rw_cnt2", 32'(cnt2), 32'd1);
    checkOutput("rw_r", {31'b0, r}, 32'd1);

    // Randomized traffic with occasional resets
    resetDut();
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 39) == 0) resetDut();
      m = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(m, $urandom_range(0, 4));
    end
    waitIdle();
    checkOutput("rand_err", {31'b0, err_timeout}, 32'd0);
    checkOutput("rand_cnt1", 32'(cnt1), 32'(m1));
    checkOutput("rand_cnt2", 32'(cnt2), 32'(m2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fork_cond2_ctrl_2ph.md
Name: fork_cond2_ctrl_2ph

Overview:
Clocked sequencer that drives a 2-channel conditional fork on a 2-phase single-rail channel. It accepts routing commands from a synchronous producer, sets cond1/cond2, issues one 2-phase request toggle, and waits for the returned acknowledge toggle before taking the next command. It also keeps per-branch token counters and flags acknowledge timeouts. It sits between synchronous control logic and the async fork's r/a/cond1/cond2 pins.

Parameters:
CNT_W, 16, width of per-branch token counters
SETUP_CYC, 2, cycles cond1/cond2 are held stable before r toggles (legal range >=1)
TIMEOUT, 1024, cycles spent waiting for ack before err_timeout sets (legal range >=1)
SYNC_STAGES, 2, flop stages synchronizing async input a (legal range >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_mask  in  2  bit0 routes the token to branch 1, bit1 routes it to branch 2
r  out  1  2-phase request to the fork; a transition means a new token
a  in  1  2-phase acknowledge from the fork; asynchronous
cond1  out  1  fork cond1; held stable for the whole transaction
cond2  out  1  fork cond2; held stable for the whole transaction
busy  out  1  a transaction is outstanding (state is not IDLE)
cnt1  out  CNT_W  tokens completed with mask bit0 set
cnt2  out  CNT_W  tokens completed with mask bit1 set
err_timeout  out  1  sticky flag: the ack wait exceeded TIMEOUT
err_clr  in  1  clears err_timeout

Behaviour:
- Reset (rst=1 at a clk edge) forces the following values: r=0, cond1=0, cond2=0, cnt1=0, cnt2=0, err_timeout=0, synchronizer flops=0, state=IDLE, cmd_ready=1, busy=0. Reset mid-transaction abandons the token. The fork must be reset in the same window so that the a phase returns to 0.
- The input a passes through SYNC_STAGES flops; a_s is the synchronized value. All logic uses a_s only.
- States: IDLE, SETUP, WAIT.
- cmd_ready=1 only in IDLE. A command is accepted on a cycle T with cmd_valid=1 and cmd_ready=1.
- IDLE, accepting cmd_mask=00: the command is dropped. There is no r toggle and no counter change. State stays IDLE, so back-to-back acceptance is possible.
- IDLE, accepting a nonzero mask: cond1=mask[0] and cond2=mask[1] are registered and visible at T+1. State goes to SETUP with setup counter=0.
- SETUP: holds cond1/cond2 for SETUP_CYC cycles. On the last cycle, r toggles, so the new r is visible at T+1+SETUP_CYC. State goes to WAIT and the wait counter clears.
- WAIT: completes when a_s==r. On that edge:
  - state goes to IDLE;
  - cnt1 increments if cond1=1, and cnt2 increments if cond2=1;
  - cond1/cond2 keep their value until the next accepted nonzero command.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Timeout: the wait counter increments each WAIT cycle and saturates. When it reaches TIMEOUT, err_timeout sets. The controller stays in WAIT, because a 2-phase token cannot be aborted. A later ack still completes the transaction normally.
- err_clr=1 clears err_timeout. If the set condition and err_clr occur in the same cycle, set wins.
- The a input toggling while not in WAIT is a protocol error and is ignored. The phase check a_s==r in IDLE is not used.
- Minimum transaction length with an instant ack: 1 (accept) + SETUP_CYC + SYNC_STAGES + 1 cycles until cmd_ready reasserts.
- r, cond1 and cond2 are driven directly from flops, with no combinational path to the outputs (glitch-free to the async fork).

Test Plan:
- Reset, then mask=01 with a looped back to r through a 3-cycle delay (defaults) -> cond1=1/cond2=0 at T+1, r 0->1 at T+3, cmd_ready high again at T+9, cnt1=1, cnt2=0.
- Three back-to-back commands with masks 11, 10, 11 and a prompt ack -> r toggles 3 times (ends at 1), cnt1=2, cnt2=3, cond stable from SETUP entry until each completion.
- mask=00 accepted -> no r toggle, counters unchanged, cmd_ready stays 1 on the next cycle.
- a held without a toggle for 1100 cycles -> err_timeout sets after 1024 WAIT cycles and busy=1. A subsequent a toggle completes the transaction with err_timeout still 1. err_clr then returns it to 0.
- CNT_W=2 with 5 mask=01 tokens -> cnt1 stops at 3.
- rst asserted during WAIT with r=1 -> next cycle r=0, cond=00, state IDLE, counters 0. After a toggles back to 0 with the fork reset, a new command completes normally.
